// File: rtl/fsm_interval_meter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_interval_meter_if
//  Purpose  : Bundles the control, measured line and result signals of the
//             interval meter.
//  Ports    : master - controller side (drives ARM/CANCEL/PULSE/ACK,
//                      observes BUSY/VALID/WIDTH_OUT/OVF)
//             slave  - meter side (the reverse directions)
//  Revision : 1.0 - initial release
// ============================================================================
interface fsm_interval_meter_if #(
    parameter int W = 8
) ();
    logic         ARM;
    logic         CANCEL;
    logic         PULSE;
    logic         ACK;
    logic         BUSY;
    logic         VALID;
    logic [W-1:0] WIDTH_OUT;
    logic         OVF;

    modport master (
        output ARM, CANCEL, PULSE, ACK,
        input  BUSY, VALID, WIDTH_OUT, OVF
    );

    modport slave (
        input  ARM, CANCEL, PULSE, ACK,
        output BUSY, VALID, WIDTH_OUT, OVF
    );
endinterface
`default_nettype wire

// File: rtl/fsm_interval_meter.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_interval_meter
//  Purpose  : Measures, in CLK cycles, the width of one complete high pulse
//             on PULSE once armed, and presents it via a VALID/ACK handshake.
//  Ports    : CLK   - system clock, rising edge
//             RESET - synchronous active-high reset
//             bus   - slave modport: ARM, CANCEL, PULSE, ACK in;
//                     BUSY, VALID, WIDTH_OUT (W bits, saturating), OVF out
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_interval_meter #(
    parameter int W = 8
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    fsm_interval_meter_if.slave bus
);

    localparam logic [W-1:0] C_MAX = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_MEAS  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] width_q, width_d;
    logic         ovf_q, ovf_d;
    logic         ovf_flag_q, ovf_flag_d;
    logic         pulse_q;
    logic         rise;

    // Only a fresh edge starts a measurement, so a pulse already high when
    // arming is skipped.
    assign rise = bus.PULSE & ~pulse_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            width_q    <= '0;
            ovf_q      <= 1'b0;
            ovf_flag_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            width_q    <= width_d;
            ovf_q      <= ovf_d;
            ovf_flag_q <= ovf_flag_d;
            pulse_q    <= bus.PULSE;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        width_d    = width_q;
        ovf_d      = ovf_q;
        ovf_flag_d = ovf_flag_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ARM) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.CANCEL) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    state_d    = S_MEAS;
                    count_d    = {{(W-1){1'b0}}, 1'b1};
                    ovf_flag_d = 1'b0;
                end
            end
            S_MEAS: begin
                if (bus.CANCEL) begin
                    state_d = S_IDLE;
                end else if (bus.PULSE) begin
                    // Saturate instead of wrapping; remember the overflow.
                    if (count_q == C_MAX) begin
                        ovf_flag_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    width_d = count_q;
                    ovf_d   = ovf_flag_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.ACK) begin
                    state_d = bus.ARM ? S_ARMED : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.BUSY      = (state_q == S_ARMED) || (state_q == S_MEAS);
    assign bus.VALID     = (state_q == S_DONE);
    assign bus.WIDTH_OUT = width_q;
    assign bus.OVF       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_interval_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_interval_meter
//  Purpose  : Self-checking bench for fsm_interval_meter (W=4): vector table,
//             directed corner sequences and randomized traffic compared with
//             a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_interval_meter;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk;
    logic rst;

    fsm_interval_meter_if #(.W(W)) bus ();

    fsm_interval_meter #(.W(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: tracks the phase with flags and the high-run length
    // as an unbounded integer; saturation is applied only when reporting.
    bit m_armed, m_meas, m_done, m_prev, m_ovf;
    int m_run, m_width;

    function automatic void model_step(bit r, bit a, bit c, bit p, bit k);
        if (r) begin
            m_armed = 0; m_meas = 0; m_done = 0; m_prev = 0;
            m_ovf = 0; m_width = 0; m_run = 0;
        end else begin
            if (m_done) begin
                if (k) begin
                    m_done  = 0;
                    m_armed = a;
                end
            end else if (m_meas) begin
                if (c) m_meas = 0;
                else if (p) m_run++;
                else begin
                    m_width = (m_run > MAX) ? MAX : m_run;
                    m_ovf   = (m_run > MAX);
                    m_meas  = 0;
                    m_done  = 1;
                end
            end else if (m_armed) begin
                if (c) m_armed = 0;
                else if (p && !m_prev) begin
                    m_armed = 0;
                    m_meas  = 1;
                    m_run   = 1;
                end
            end else if (a) begin
                m_armed = 1;
            end
            m_prev = p;
        end
    endfunction

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check_model(string tag);
        check({tag, ".busy"},  int'(bus.BUSY),      int'(m_armed | m_meas));
        check({tag, ".valid"}, int'(bus.VALID),     int'(m_done));
        check({tag, ".width"}, int'(bus.WIDTH_OUT), m_width);
        check({tag, ".ovf"},   int'(bus.OVF),       int'(m_ovf));
    endfunction

    // One clock: apply inputs, take the edge, advance the model, compare.
    task automatic cyc(string tag, bit r, bit a, bit c, bit p, bit k);
        rst = r; bus.ARM = a; bus.CANCEL = c; bus.PULSE = p; bus.ACK = k;
        @(posedge clk);
        #1;
        model_step(r, a, c, p, k);
        check_model(tag);
    endtask

    task automatic expect_result(string tag, bit v, int w, bit o);
        check({tag, ".valid"}, int'(bus.VALID),     int'(v));
        check({tag, ".width"}, int'(bus.WIDTH_OUT), w);
        check({tag, ".ovf"},   int'(bus.OVF),       int'(o));
    endtask

    // Arm, drive a P-cycle pulse, and return with the result in DONE.
    task automatic measure(string tag, int p);
        cyc(tag, 0, 1, 0, 0, 0);
        for (int i = 0; i < p; i++) cyc(tag, 0, 0, 0, 1, 0);
        cyc(tag, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit rst, arm, cancel, pulse, ack;
        bit busy, valid;
        int width;
        bit ovf;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int  rem;
        bit  lvl;

        tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0,  1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0,  1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 0,  1, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 0,  1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 0,  1, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 0,  1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0,  0, 1, 5, 0};
        tbl[8]  = '{0, 0, 0, 0, 0,  0, 1, 5, 0};
        tbl[9]  = '{0, 0, 0, 0, 1,  0, 0, 5, 0};
        tbl[10] = '{0, 0, 0, 1, 0,  0, 0, 5, 0};
        tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 5, 0};

        rst = 1; bus.ARM = 0; bus.CANCEL = 0; bus.PULSE = 0; bus.ACK = 0;
        m_armed = 0; m_meas = 0; m_done = 0; m_prev = 0;
        m_ovf = 0; m_width = 0; m_run = 0;

        // Basic 5-cycle measurement from the vector table.
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; bus.ARM = tbl[i].arm; bus.CANCEL = tbl[i].cancel;
            bus.PULSE = tbl[i].pulse; bus.ACK = tbl[i].ack;
            @(posedge clk);
            #1;
            model_step(tbl[i].rst, tbl[i].arm, tbl[i].cancel, tbl[i].pulse, tbl[i].ack);
            check($sformatf("tbl%0d.busy", i),  int'(bus.BUSY),      int'(tbl[i].busy));
            check($sformatf("tbl%0d.valid", i), int'(bus.VALID),     int'(tbl[i].valid));
            check($sformatf("tbl%0d.width", i), int'(bus.WIDTH_OUT), tbl[i].width);
            check($sformatf("tbl%0d.ovf", i),   int'(bus.OVF),       int'(tbl[i].ovf));
        end

        // Pulse lengths at and beyond the saturation boundary.
        measure("p1", 1);   expect_result("p1", 1, 1, 0);   cyc("p1", 0, 0, 0, 0, 1);
        measure("p15", 15); expect_result("p15", 1, 15, 0); cyc("p15", 0, 0, 0, 0, 1);
        measure("p16", 16); expect_result("p16", 1, 15, 1); cyc("p16", 0, 0, 0, 0, 1);
        measure("p20", 20); expect_result("p20", 1, 15, 1); cyc("p20", 0, 0, 0, 0, 1);

        // Pulse already high at arming is skipped; the next full pulse counts.
        cyc("pre", 0, 1, 0, 1, 0);
        cyc("pre", 0, 0, 0, 1, 0);
        cyc("pre", 0, 0, 0, 1, 0);
        cyc("pre", 0, 0, 0, 0, 0);
        check("pre.still_armed", int'(bus.BUSY), 1);
        for (int i = 0; i < 4; i++) cyc("pre", 0, 0, 0, 1, 0);
        cyc("pre", 0, 0, 0, 0, 0);
        expect_result("pre", 1, 4, 0);
        cyc("pre", 0, 0, 0, 0, 1);

        // CANCEL on the 3rd high cycle; result keeps its prior value.
        cyc("can", 0, 1, 0, 0, 0);
        cyc("can", 0, 0, 0, 1, 0);
        cyc("can", 0, 0, 0, 1, 0);
        cyc("can", 0, 0, 1, 1, 0);
        check("can.busy", int'(bus.BUSY), 0);
        for (int i = 0; i < 3; i++) cyc("can", 0, 0, 0, 0, 0);
        expect_result("can", 0, 4, 0);
        cyc("can_idle", 0, 0, 0, 1, 0);
        cyc("can_idle", 0, 0, 0, 1, 0);
        cyc("can_idle", 0, 0, 0, 0, 0);
        expect_result("can_idle", 0, 4, 0);

        // DONE holds through PULSE/ARM/CANCEL activity until ACK.
        measure("hold", 5);
        for (int i = 0; i < 10; i++) cyc("hold", 0, i[1], i[2], i[0], 0);
        expect_result("hold", 1, 5, 0);
        cyc("b2b", 0, 1, 0, 0, 1);
        check("b2b.busy", int'(bus.BUSY), 1);
        for (int i = 0; i < 7; i++) cyc("b2b", 0, 0, 0, 1, 0);
        cyc("b2b", 0, 0, 0, 0, 0);
        expect_result("b2b", 1, 7, 0);
        cyc("b2b", 0, 0, 0, 0, 1);

        // Reset in the middle of a measurement.
        cyc("rstm", 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc("rstm", 0, 0, 0, 1, 0);
        cyc("rstm", 1, 0, 0, 1, 0);
        check("rstm.busy", int'(bus.BUSY), 0);
        expect_result("rstm", 0, 0, 0);
        cyc("rstm", 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        rem = 0;
        lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r, a, c, k;
            if (rem == 0) begin
                lvl = ~lvl;
                rem = (($urandom % 8) == 0) ? int'($urandom_range(14, 24))
                                             : int'($urandom_range(1, 8));
            end
            rem--;
            r = ($urandom_range(0, 299) == 0);
            a = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 24) == 0);
            k = ($urandom_range(0, 3) == 0);
            cyc("rnd", r, a, c, lvl, k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
